// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter: sizes, hold default, FSM states.
package rr_grant_arbiter_pkg;

  localparam int N            = 8;
  localparam int IDX_W        = 3;
  localparam int HOLD_W       = 8;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_grant_arbiter_grant_encoder.sv
// One-hot to binary index encoder; an all-zero input encodes to index 0.
module grant_encoder
  import rr_grant_arbiter_pkg::*;
(
  input  logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  // OR together the indices of all set bits; exact for one-hot, 0 for zero input
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with a bounded hold time and a one-cycle
// turnaround gap between owners. Grant, index and valid are all registered.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N-1:0]     REQ,
  output logic [N-1:0]     GNT,
  output logic [IDX_W-1:0] CODE,
  output logic             VALID,
  output logic             TIMEOUT
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t              state_q, state_nxt;
  logic [IDX_W-1:0]    ptr_q, ptr_nxt;
  logic [HOLD_W-1:0]   hold_q, hold_nxt;
  logic [N-1:0]        gnt_nxt;
  logic [IDX_W-1:0]    code_nxt;
  logic                timeout_nxt;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic                others_pending;

  // Rotating priority search: first set request starting at ptr_q, wrapping 7 -> 0
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && REQ[ptr_q + IDX_W'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + IDX_W'(k);
      end
    end
  end

  assign others_pending = |(REQ & ~GNT);

  // Next-state logic; the current owner index is the registered CODE
  always_comb begin
    state_nxt   = state_q;
    gnt_nxt     = GNT;
    ptr_nxt     = ptr_q;
    hold_nxt    = hold_q;
    timeout_nxt = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        gnt_nxt = '0;
        if (win_found) begin
          state_nxt        = ST_GRANT;
          gnt_nxt[win_idx] = 1'b1;
          hold_nxt         = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!REQ[CODE]) begin
          state_nxt = ST_GAP;
          gnt_nxt   = '0;
          ptr_nxt   = CODE + IDX_W'(1);
        end else if (hold_q == HOLD_LAST && others_pending) begin
          state_nxt   = ST_GAP;
          gnt_nxt     = '0;
          ptr_nxt     = CODE + IDX_W'(1);
          timeout_nxt = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_nxt = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  grant_encoder u_enc (
    .onehot (gnt_nxt),
    .idx    (code_nxt)
  );

  // State and output registers; reset clears everything including a live grant
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      GNT     <= '0;
      CODE    <= '0;
      VALID   <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
      hold_q  <= hold_nxt;
      GNT     <= gnt_nxt;
      CODE    <= code_nxt;
      VALID   <= |gnt_nxt;
      TIMEOUT <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: two instances (MAX_HOLD 4 and 16) share stimulus
// and are compared every cycle against an owner/pointer reference model.
module tb_rr_grant_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] REQ;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] code_a, code_b;
  logic       valid_a, valid_b, timeout_a, timeout_b;

  rr_grant_arbiter #(.MAX_HOLD(4)) dut_a (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .GNT(gnt_a), .CODE(code_a), .VALID(valid_a), .TIMEOUT(timeout_a)
  );

  rr_grant_arbiter #(.MAX_HOLD(16)) dut_b (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .GNT(gnt_b), .CODE(code_b), .VALID(valid_b), .TIMEOUT(timeout_b)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: owner (-1 = none), priority pointer, cycles held so far
  int m_owner [2];
  int m_ptr   [2];
  int m_held  [2];
  bit m_to    [2];
  int m_max   [2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        m_owner[i] = -1; m_ptr[i] = 0; m_held[i] = 0; m_to[i] = 0;
      end else if (m_owner[i] >= 0) begin
        if (!REQ[m_owner[i]]) begin
          m_ptr[i] = (m_owner[i] + 1) % 8; m_owner[i] = -1; m_to[i] = 0;
        end else if (m_held[i] >= m_max[i] && (REQ & ~(8'd1 << m_owner[i])) != 8'd0) begin
          m_ptr[i] = (m_owner[i] + 1) % 8; m_owner[i] = -1; m_to[i] = 1;
        end else begin
          m_held[i] = m_held[i] + 1; m_to[i] = 0;
        end
      end else begin
        m_to[i] = 0;
        for (int k = 0; k < 8; k++) begin
          if (m_owner[i] < 0 && REQ[(m_ptr[i] + k) % 8]) begin
            m_owner[i] = (m_ptr[i] + k) % 8;
            m_held[i]  = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [12:0] exp_vec(int i);
    logic [7:0] g;
    logic [2:0] c;
    g = (m_owner[i] >= 0) ? (8'd1 << m_owner[i]) : 8'd0;
    c = (m_owner[i] >= 0) ? 3'(m_owner[i]) : 3'd0;
    return {g, c, (m_owner[i] >= 0), m_to[i]};
  endfunction

  function automatic logic [12:0] obs_vec(int i);
    return (i == 0) ? {gnt_a, code_a, valid_a, timeout_a}
                    : {gnt_b, code_b, valid_b, timeout_b};
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = 8'h00;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 8'hFF;
    tick(); tick();
    checks++;
    if ({gnt_a, code_a, valid_a, timeout_a} !== 13'd0) begin
      errors++; $display("FAIL reset_a: got %h want 0000", {gnt_a, code_a, valid_a, timeout_a});
    end
    checks++;
    if ({gnt_b, code_b, valid_b, timeout_b} !== 13'd0) begin
      errors++; $display("FAIL reset_b: got %h want 0000", {gnt_b, code_b, valid_b, timeout_b});
    end
    RST = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    REQ = 8'h01;
    tick();
    checks++;
    if (gnt_a !== 8'h01 || code_a !== 3'd0 || valid_a !== 1'b1) begin
      errors++; $display("FAIL single_grant: gnt=%h code=%0d valid=%b want 01/0/1", gnt_a, code_a, valid_a);
    end
    tick(); tick();
    REQ = 8'h00;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (gnt_a !== 8'h00 || valid_a !== 1'b0 || timeout_a !== 1'b0) begin
        errors++; $display("FAIL single_release t%0d: gnt=%h valid=%b to=%b want 00/0/0", t, gnt_a, valid_a, timeout_a);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL single_model inst%0d cyc%0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] eg;
    logic       et;
    do_reset();
    REQ = 8'hFF;
    for (int c = 0; c < 45; c++) begin
      tick();
      eg = (c % 5 < 4) ? (8'd1 << ((c / 5) % 8)) : 8'd0;
      et = (c % 5 == 4);
      checks++;
      if (gnt_a !== eg || timeout_a !== et || code_a !== ((c % 5 < 4) ? 3'((c / 5) % 8) : 3'd0)) begin
        errors++; $display("FAIL rotation c%0d: gnt=%h code=%0d to=%b want %h/%b", c, gnt_a, code_a, timeout_a, eg, et);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL rotation_model inst%0d cyc%0d: got %h want %h", i, cyc, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_release_handover();
    do_reset();
    REQ = 8'h24;
    tick();
    checks++;
    if (gnt_a !== 8'h04 || code_a !== 3'd2) begin
      errors++; $display("FAIL handover_first: gnt=%h code=%0d want 04/2", gnt_a, code_a);
    end
    tick(); tick();
    REQ = 8'h20;
    tick();
    checks++;
    if (gnt_a !== 8'h00 || timeout_a !== 1'b0 || gnt_b !== 8'h00 || timeout_b !== 1'b0) begin
      errors++; $display("FAIL handover_gap: gnt=%h/%h to=%b/%b want 00 0", gnt_a, gnt_b, timeout_a, timeout_b);
    end
    tick();
    checks++;
    if (gnt_a !== 8'h20 || code_a !== 3'd5 || gnt_b !== 8'h20 || code_b !== 3'd5) begin
      errors++; $display("FAIL handover_next: gnt=%h/%h code=%0d/%0d want 20/5", gnt_a, gnt_b, code_a, code_b);
    end
  endtask

  task automatic test_sole();
    do_reset();
    REQ = 8'h80;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (gnt_a !== 8'h80 || code_a !== 3'd7 || timeout_a !== 1'b0 ||
          gnt_b !== 8'h80 || code_b !== 3'd7 || timeout_b !== 1'b0) begin
        errors++; $display("FAIL sole c%0d: gnt=%h/%h code=%0d/%0d to=%b/%b want 80/7/0",
                           c, gnt_a, gnt_b, code_a, code_b, timeout_a, timeout_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    REQ = 8'h20;
    tick(); tick();
    RST = 1'b1;
    tick();
    checks++;
    if (gnt_a !== 8'h00 || code_a !== 3'd0 || valid_a !== 1'b0) begin
      errors++; $display("FAIL reset_mid: gnt=%h code=%0d valid=%b want 00/0/0", gnt_a, code_a, valid_a);
    end
    RST = 1'b0;
    REQ = 8'hFF;
    tick();
    checks++;
    if (gnt_a !== 8'h01 || code_a !== 3'd0 || gnt_b !== 8'h01) begin
      errors++; $display("FAIL reset_ptr: gnt=%h/%h code=%0d want 01/0", gnt_a, gnt_b, code_a);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    REQ = 8'h80;
    tick();
    REQ = 8'h01;
    tick();
    checks++;
    if (gnt_a !== 8'h00 || timeout_a !== 1'b0) begin
      errors++; $display("FAIL wrap_gap: gnt=%h to=%b want 00/0", gnt_a, timeout_a);
    end
    REQ = 8'h81;
    tick();
    checks++;
    if (gnt_a !== 8'h01 || code_a !== 3'd0 || gnt_b !== 8'h01 || code_b !== 3'd0) begin
      errors++; $display("FAIL wrap_grant: gnt=%h/%h code=%0d/%0d want 01/0", gnt_a, gnt_b, code_a, code_b);
    end
  endtask

  task automatic test_random();
    do_reset();
    REQ = 8'(($urandom));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) REQ = REQ ^ (8'd1 << $urandom_range(7));
      if ($urandom_range(15) == 0) REQ = 8'(($urandom)) & 8'(($urandom));
      RST = ($urandom_range(299) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i)) begin
          errors++; $display("FAIL random inst%0d cyc%0d req=%h: got %h want %h", i, cyc, REQ, obs_vec(i), exp_vec(i));
        end
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    m_max[0] = 4;
    m_max[1] = 16;
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1; m_ptr[i] = 0; m_held[i] = 0; m_to[i] = 0;
    end
    RST = 1'b1;
    REQ = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_release_handover();
    test_sole();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
